// File: rtl/aes_128.sv
// aes_128: fully pipelined AES-128 encryptor (FIPS-197 byte order, bit[127:120] = byte 0).
// One input stage (state^key) followed by ten rounds of two stages each
// (SubBytes/ShiftRows, then MixColumns/AddRoundKey), plus a registered output.
// The round key is expanded in-pipeline next to its own block, so every cycle
// may carry a different key. A new block is accepted every clock; its
// ciphertext appears on out 21 rising edges after the edge that sampled it.
// Optional feature: define AES_VALID_EN to add in_valid/out_valid, a tag that
// travels through a shift register alongside each block.
module aes_128 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
`ifdef AES_VALID_EN
    ,
    input  logic         in_valid,
    output logic         out_valid
`endif
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants for rounds 1..10, round 1 in the most significant byte.
    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    // Stage registers: st_b/key_b hold a finished round (index 0 = input stage),
    // st_a/key_a hold the SubBytes/ShiftRows half of a round with its round key.
    logic [127:0] st_b  [0:10];
    logic [127:0] key_b [0:9];
    logic [127:0] st_a  [1:10];
    logic [127:0] key_a [1:10];

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX_TABLE[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (row r, column c) lives at index r + 4c; ShiftRows rotates row r left by r.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8 * (r + 4 * c) -: 8] = sbox(s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8]);
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] res;
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            b0 = xtime(a0);
            b1 = xtime(a1);
            b2 = xtime(a2);
            b3 = xtime(a3);
            res[127 - 32 * c -: 8] = b0 ^ (b1 ^ a1) ^ a2 ^ a3;
            res[119 - 32 * c -: 8] = a0 ^ b1 ^ (b2 ^ a2) ^ a3;
            res[111 - 32 * c -: 8] = a0 ^ a1 ^ b2 ^ (b3 ^ a3);
            res[103 - 32 * c -: 8] = (b0 ^ a0) ^ a1 ^ a2 ^ b3;
        end
        return res;
    endfunction

    // One step of the key schedule: RotWord, SubWord, Rcon on the last word, then chain.
    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Advance every block and its round key one stage per clock; reset empties the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r <= 10; r++) st_b[r] <= '0;
            for (int r = 0; r <= 9; r++)  key_b[r] <= '0;
            for (int r = 1; r <= 10; r++) begin
                st_a[r]  <= '0;
                key_a[r] <= '0;
            end
            out <= '0;
        end else begin
            st_b[0]  <= state ^ key;
            key_b[0] <= key;
            for (int r = 1; r <= 10; r++) begin
                st_a[r]  <= sub_shift(st_b[r - 1]);
                key_a[r] <= key_next(key_b[r - 1], RCON[79 - 8 * (r - 1) -: 8]);
                if (r == 10) begin
                    st_b[r] <= st_a[r] ^ key_a[r];
                end else begin
                    st_b[r]  <= mix_columns(st_a[r]) ^ key_a[r];
                    key_b[r] <= key_a[r];
                end
            end
            out <= st_b[10];
        end
    end

`ifdef AES_VALID_EN
    logic [20:0] valid_pipe;

    // Carry the block-valid tag alongside its block so out_valid lines up with out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe <= '0;
            out_valid  <= 1'b0;
        end else begin
            valid_pipe <= {valid_pipe[19:0], in_valid};
            out_valid  <= valid_pipe[20];
        end
    end
`endif

endmodule

// File: tb/tb_aes_128.sv
// tb_aes_128: randomized self-checking bench for aes_128 against a byte-level
// AES-128 model (S-box derived from the GF(2^8) inverse, full key schedule up front).
module tb_aes_128;

    logic         clk = 1'b0;
    bit           clk_run = 1'b1;
    logic         rst_n;
    logic [127:0] state;
    logic [127:0] key;
    logic [127:0] out;
`ifdef AES_VALID_EN
    logic         in_valid;
    logic         out_valid;
    bit           exp_vld [0:1023];
`endif

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    logic [127:0] exp_out [0:1023];
    bit           exp_chk [0:1023];
    logic [7:0]   sbox_ref [0:255];

    aes_128 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .state (state),
        .key   (key),
        .out   (out)
`ifdef AES_VALID_EN
        ,
        .in_valid  (in_valid),
        .out_valid (out_valid)
`endif
    );

    // Free-running clock that can be frozen low to test holding behaviour.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] aesRef(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [0:43];
        logic [7:0]   st [0:15];
        logic [7:0]   tmp [0:15];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]], sbox_ref[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sbox_ref[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    st[r + 4 * c] = tmp[r + 4 * ((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4 * c];
                    a1 = st[4 * c + 1];
                    a2 = st[4 * c + 2];
                    a3 = st[4 * c + 3];
                    st[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4 * rnd + i / 4][31 - 8 * (i % 4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = st[i];
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h (edge %0d)", tag, observed, expected, edge_cnt);
        end
    endtask

    // Compare the outputs due after the most recent edge with the model.
    task automatic checkCycle();
        int idx;
        idx = edge_cnt - 21;
        if (idx >= 0 && exp_chk[idx]) checkOutput("out", out, exp_out[idx]);
`ifdef AES_VALID_EN
        checkOutput("out_valid", {127'b0, out_valid}, {127'b0, (idx >= 0) ? exp_vld[idx] : 1'b0});
`endif
    endtask

    // Drive one block for the next rising edge, record its expectation, then check.
    task automatic applyStimulus(input logic [127:0] s, input logic [127:0] k, input bit v,
                                 input logic [127:0] expected);
        state = s;
        key   = k;
`ifdef AES_VALID_EN
        in_valid = v;
        exp_vld[edge_cnt + 1] = v;
`endif
        exp_out[edge_cnt + 1] = expected;
        exp_chk[edge_cnt + 1] = 1'b1;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        checkCycle();
    endtask

    task automatic randomStep(input bit v);
        logic [127:0] s;
        logic [127:0] k;
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(s, k, v, aesRef(s, k));
    endtask

    initial begin
        logic [7:0] inv;
        // S-box from multiplicative inverse plus affine transform.
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 1024; i++) begin
            exp_chk[i] = 1'b0;
            exp_out[i] = '0;
`ifdef AES_VALID_EN
            exp_vld[i] = 1'b0;
`endif
        end

        rst_n = 1'b0;
        state = '0;
        key   = '0;
`ifdef AES_VALID_EN
        in_valid = 1'b0;
`endif
        #3;
        checkOutput("reset_out", out, 128'h0);
`ifdef AES_VALID_EN
        checkOutput("reset_out_valid", {127'b0, out_valid}, 128'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_hold_out", out, 128'h0);
        rst_n = 1'b1;

        // Known-answer vectors on consecutive cycles, then a random stream.
        applyStimulus(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                      1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        applyStimulus(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                      1'b1, 128'h3925841d02dc09fbdc118597196a0b32);
        applyStimulus(128'h0, 128'h0, 1'b1, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        for (int n = 0; n < 200; n++) randomStep((n % 9) != 4);
        for (int n = 0; n < 12; n++) randomStep(1'b1);

        // Freeze the clock with changing inputs; out must hold its value.
        clk_run = 1'b0;
        state = {$urandom, $urandom, $urandom, $urandom};
        key   = {$urandom, $urandom, $urandom, $urandom};
        #42;
        checkCycle();
        clk_run = 1'b1;
        for (int n = 0; n < 13; n++) randomStep(1'b1);

        // Reset in the middle of a streaming run discards everything in flight.
        for (int n = 0; n < 10; n++) randomStep(1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_out", out, 128'h0);
`ifdef AES_VALID_EN
        checkOutput("midrun_reset_out_valid", {127'b0, out_valid}, 128'h0);
`endif
        for (int i = 0; i <= edge_cnt; i++) begin
            exp_chk[i] = 1'b0;
`ifdef AES_VALID_EN
            exp_vld[i] = 1'b0;
`endif
        end
        #2;
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) randomStep(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
